// File: rtl/vga_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R). The master modport issues reads, and the slave
// modport answers them.
interface vga_rd_arbiter_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rresp, rdata, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rresp, rdata, rlast, rid
  );
endinterface

// File: rtl/vga_rd_arbiter.sv
// Two-way AXI4 read arbiter: scan-out (s0) has urgent priority with a starvation cap,
// otherwise round-robin; one whole burst in flight, with beat tracking against arlen.
module vga_rd_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             s0_urgent,
  vga_rd_arbiter_if.slave  s0,
  vga_rd_arbiter_if.slave  s1,
  vga_rd_arbiter_if.master m,
  output logic             proto_err
);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t      state_r, state_s;
  logic        grant_r, last_grant_r;
  logic [7:0]  starve_cnt_r;
  logic [8:0]  beat_cnt_r;
  logic [31:0] araddr_r;
  logic [3:0]  arid_r;
  logic [7:0]  arlen_r;
  logic [2:0]  arsize_r;
  logic [1:0]  arburst_r;

  logic        sel_s, override_s, accept_s, rready_sel_s, r_hs_s;
  logic [8:0]  beat_next_s, beat_end_s;

  // Grant selection among the requesters that are currently valid
  always_comb begin
    sel_s      = ~last_grant_r;
    override_s = 1'b0;
    if (s0.arvalid && !s1.arvalid) begin
      sel_s = 1'b0;
    end else if (s1.arvalid && !s0.arvalid) begin
      sel_s = 1'b1;
    end else if (s0_urgent && (starve_cnt_r < STARVE_LIM)) begin
      sel_s      = 1'b0;
      override_s = s1.arvalid;
    end else begin
      sel_s = ~last_grant_r;
    end
  end

  // Reset gating keeps arready low while resetn is held, even with arvalid present
  assign accept_s     = resetn && (state_r == IDLE) && (s0.arvalid || s1.arvalid);
  assign rready_sel_s = grant_r ? s1.rready : s0.rready;
  assign r_hs_s       = (state_r == DATA) && m.rvalid && rready_sel_s;
  assign beat_next_s  = beat_cnt_r + 9'd1;
  assign beat_end_s   = {1'b0, arlen_r} + 9'd1;

  assign m.araddr  = araddr_r;
  assign m.arid    = arid_r;
  assign m.arlen   = arlen_r;
  assign m.arsize  = arsize_r;
  assign m.arburst = arburst_r;

  // Next-state logic, handshake outputs and R-channel routing
  always_comb begin
    state_s    = state_r;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rresp   = 2'd0;
    s0.rdata   = 64'd0;
    s0.rlast   = 1'b0;
    s0.rid     = 4'd0;
    s1.rvalid  = 1'b0;
    s1.rresp   = 2'd0;
    s1.rdata   = 64'd0;
    s1.rlast   = 1'b0;
    s1.rid     = 4'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          s0.arready = ~sel_s;
          s1.arready = sel_s;
          state_s    = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        m.arvalid = 1'b1;
        if (m.arready) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        m.rready = rready_sel_s;
        if (grant_r) begin
          s1.rvalid = m.rvalid;
          s1.rresp  = m.rresp;
          s1.rdata  = m.rdata;
          s1.rlast  = m.rlast;
          s1.rid    = m.rid;
        end else begin
          s0.rvalid = m.rvalid;
          s0.rresp  = m.rresp;
          s0.rdata  = m.rdata;
          s0.rlast  = m.rlast;
          s0.rid    = m.rid;
        end
        if (r_hs_s && m.rlast) begin
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant bookkeeping, AR payload latch and beat tracking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      starve_cnt_r <= 8'd0;
      beat_cnt_r   <= 9'd0;
      araddr_r     <= 32'd0;
      arid_r       <= 4'd0;
      arlen_r      <= 8'd0;
      arsize_r     <= 3'd0;
      arburst_r    <= 2'd0;
      proto_err    <= 1'b0;
    end else begin
      if (accept_s) begin
        grant_r      <= sel_s;
        last_grant_r <= sel_s;
        beat_cnt_r   <= 9'd0;
        araddr_r     <= sel_s ? s1.araddr  : s0.araddr;
        arid_r       <= sel_s ? s1.arid    : s0.arid;
        arlen_r      <= sel_s ? s1.arlen   : s0.arlen;
        arsize_r     <= sel_s ? s1.arsize  : s0.arsize;
        arburst_r    <= sel_s ? s1.arburst : s0.arburst;
        // The override only fires below the limit, so the count saturates there
        if (sel_s) begin
          starve_cnt_r <= 8'd0;
        end else if (override_s) begin
          starve_cnt_r <= starve_cnt_r + 8'd1;
        end
      end
      if (r_hs_s) begin
        beat_cnt_r <= beat_next_s;
        if (m.rlast ? (beat_next_s != beat_end_s) : (beat_next_s == beat_end_s)) begin
          proto_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/vga_rd_arbiter.md
# vga_rd_arbiter

Two-way AXI4 read-channel arbiter that lets the VGA scan-out fetcher and a second read requester (the CPU-side framebuffer readback path) share the single AXI4 read master port toward memory. Requester 0 (scan-out) gets strict priority while its line FIFO asserts `s0_urgent`. Otherwise requesters alternate round-robin. Whole bursts are granted atomically, and the arbiter tracks each burst's beats against the latched length. Write channels are not handled here and bypass the block.

## Interface
Parameters:
- `STARVE_MAX`, default 8: maximum consecutive urgent grants to requester 0 while requester 1 waits. Legal range 1..255.

Ports:
- `clock`  in  1  single clock domain.
- `resetn`  in  1  reset, asynchronous, active-low.
- `s0_urgent`  in  1  scan-out FIFO below low-water mark.
- `sN_arvalid`/`sN_arready`  in/out  1/1  AR handshake for requester N (N=0,1).
- `sN_araddr`/`sN_arid`/`sN_arlen`/`sN_arsize`/`sN_arburst`  in  32/4/8/3/2  AR payload for requester N.
- `sN_rvalid`/`sN_rready`  out/in  1/1  R handshake for requester N.
- `sN_rresp`/`sN_rdata`/`sN_rlast`/`sN_rid`  out  2/64/1/4  R payload for requester N.
- `m_arvalid`/`m_arready`  out/in  1/1  AR handshake to memory.
- `m_araddr`/`m_arid`/`m_arlen`/`m_arsize`/`m_arburst`  out  32/4/8/3/2  AR payload to memory.
- `m_rvalid`/`m_rready`  in/out  1/1  R handshake from memory.
- `m_rresp`/`m_rdata`/`m_rlast`/`m_rid`  in  2/64/1/4  R payload from memory.
- `proto_err`  out  1  sticky flag: beat count disagreed with `arlen`+1.

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE, grant selection:**
  - If only one `sN_arvalid` is high, that requester is selected.
  - If both are high, `s0_urgent`=1 and `starve_cnt` < `STARVE_MAX`, requester 0 is selected.
  - Otherwise the requester other than `last_grant` is selected.
- **IDLE, acceptance:** the selected requester gets `sN_arready`=1 combinationally in the same cycle. On that handshake:
  - latch the AR payload unmodified (no ID remap);
  - set `grant` and `last_grant`;
  - load `beat_cnt`=0;
  - go to ADDR.
- **starve_cnt:**
  - Increments on an urgent-override grant to requester 0 while `s1_arvalid`=1.
  - Clears on any grant to requester 1.
  - Saturates at `STARVE_MAX`.
- **ADDR:** `m_arvalid`=1 with the latched payload, held stable until `m_arready`. On the handshake go to DATA. All `sN_arready`=0.
- **DATA, routing:**
  - `s[grant]_r*` = `m_r*`; `m_rready` = `s[grant]_rready`.
  - The non-granted `sN_rvalid`=0 and its payload is 0.
- **DATA, beat tracking:**
  - Each R handshake increments `beat_cnt` (9-bit; no wrap for `arlen`≤255).
  - On a handshake with `m_rlast`=1, go to IDLE.
  - If the beat count on that `rlast` ≠ latched `arlen`+1, set `proto_err`.
  - If `beat_cnt` reaches `arlen`+1 with `rlast`=0, set `proto_err` and stay in DATA until `rlast` arrives.
- `proto_err` is cleared only by reset.
- `m_rvalid` in IDLE/ADDR is ignored and `m_rready`=0 there.
- `s0_urgent` changing mid-burst has no effect; it is sampled only in IDLE.

## Timing
- **Reset values:**
  - state IDLE; `last_grant`=1 (requester 0 wins the first tie); `starve_cnt`=0; `beat_cnt`=0;
  - `m_arvalid`=0, `m_rready`=0, all `sN_arready`=0, all `sN_rvalid`=0, `proto_err`=0;
  - `m_ar*` payload and `sN_r*` payload are 0.
- **Reset mid-burst:** asynchronous clear to the above. The in-flight burst is abandoned and its remaining beats are the memory side's responsibility.
- **Address latency:** upstream AR handshake in cycle N → `m_arvalid` high in cycle N+1 at the earliest.
- **Data latency:** R path is combinational, 0 cycles added.
- **Back-to-back:** after the `rlast` handshake in cycle M, the next upstream `arready` can occur in M+1. Minimum one arbiter cycle between bursts.
- **Outstanding transactions:** only one burst outstanding at a time.

## Test plan
- **Single requester:** `s1` only, `arlen`=3, `araddr`=0x8000_0040 → `s1_arready` in cycle 0, `m_arvalid` in cycle 1 with identical payload, 4 beats routed to `s1`, `s0_rvalid` never high, `proto_err`=0.
- **Round-robin:** both request continuously, `s0_urgent`=0, `arlen`=0 → grant sequence 0,1,0,1 starting from reset.
- **Urgent override and anti-starvation:** `STARVE_MAX`=8, `s0_urgent`=1, both always requesting → eight grants to 0, then one to 1, then eight to 0.
- **Backpressure:** `m_arready` held low 5 cycles → `m_araddr` stable throughout. `s0_rready` toggling each cycle → `m_rready` mirrors it and no beat is lost or duplicated.
- **Protocol errors:**
  - `arlen`=3 with `rlast` on beat 2 → return to IDLE and `proto_err`=1.
  - `arlen`=1 with `rlast` only on beat 4 → `proto_err`=1, and DATA is exited on beat 4.
- **Reset mid-DATA:** `resetn` low after beat 1 of 4 → all outputs return to reset values immediately. After release, a new request from `s0` is granted normally.
